sync_fifo_512: RTL and testbench
================================

SYNC_FIFO_512 -- requirements
Module: sync_fifo_512

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 40: word width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 9: storage depth is 2**ADDR_WIDTH words (512 by default).
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge except reset.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-005 SHALL have port din, input, DATA_WIDTH bits: write data.
REQ-006 SHALL have port wr_en, input, 1 bit: write request.
REQ-007 SHALL have port rd_en, input, 1 bit: read request.
REQ-008 SHALL have port dout, output, DATA_WIDTH bits: registered read data.
REQ-009 SHALL have port full, output, 1 bit: high when 512 words are stored.
REQ-010 SHALL have port empty, output, 1 bit: high when 0 words are stored.

Function
REQ-011 SHALL be a synchronous first-in-first-out buffer; words are read out in exactly the order written, with no loss or duplication.
REQ-012 SHALL accept a write on a rising clk edge iff wr_en=1 and full=0 at that edge; din is stored at the write pointer, and the write pointer increments modulo 512.
REQ-013 SHALL accept a read on a rising clk edge iff rd_en=1 and empty=0 at that edge; the oldest word is loaded into dout at that edge, and the read pointer increments modulo 512.
REQ-014 SHALL use standard (non-first-word-fall-through) read timing: dout is valid one edge after the accepted read and holds its value until the next accepted read.
REQ-015 SHALL ignore a write while full (overflow): no storage change, no pointer or count change.
REQ-016 SHALL ignore a read while empty (underflow): dout holds, and no pointer or count change occurs.
REQ-017 SHALL maintain an occupancy count from 0 to 512 (ADDR_WIDTH+1 bits), updated per edge:
- +1 on write only
- -1 on read only
- unchanged on both or neither
REQ-018 SHALL, when both requests are accepted on the same edge (0 < count < 512), perform both the write and the read, leaving the count unchanged.
REQ-019 SHALL, when full and both wr_en and rd_en are high, perform only the read; the count becomes 511 and din is discarded.
REQ-020 SHALL, when empty and both wr_en and rd_en are high, perform only the write; the count becomes 1 and dout is unchanged.
REQ-021 SHALL register full and empty so they reflect the updated count immediately after the edge:
- full = (count==512)
- empty = (count==0)
- never both high
REQ-022 SHALL handle pointer wrap-around (511 -> 0) transparently, with no effect on data order or flags.
REQ-023 SHALL implement storage as a 512 x DATA_WIDTH array with synchronous write and synchronous (registered) read; the storage array is not reset.

Reset
REQ-024 SHALL, while rst=1, asynchronously force:
- read pointer, write pointer and count to 0
- dout to 0
- empty to 1, full to 0
REQ-025 SHALL ignore wr_en and rd_en while rst=1, including when rst asserts mid-operation; all stored contents are treated as discarded.
REQ-026 SHALL resume normal operation on the first rising clk edge after rst deasserts, in the empty state.

Verification
REQ-027 Reset: pulse rst high for 50 ns mid-stream with words stored -> empty=1, full=0, dout=0 immediately; a subsequent read request without writes leaves dout=0.
REQ-028 Fill: after reset, hold wr_en=1 and write din=1,2,3,... one per clock -> empty falls after the first edge, full rises exactly after the 512th accepted write (din=512), and the 513th write is ignored.
REQ-029 Drain: from full, hold rd_en=1, wr_en=0 -> dout=1,2,...,512 on successive edges, full falls after the first read, empty rises after the 512th read, and dout holds 512 thereafter.
REQ-030 Wrap: write 300, read 300, then write 400 and read 400 -> data in order, with no spurious full/empty across the pointer wrap.
REQ-031 Simultaneous: at count=5, wr_en=rd_en=1 for 10 clocks -> count stays 5 with flags steady; at full, both high -> count 511 and the written word is discarded; at empty, both high -> count 1 and dout unchanged.

Source files
------------

// File: rtl/sync_fifo_512.sv
// -----------------------------------------------------------------------------
// sync_fifo_512
//   Single-clock first-in-first-out buffer. The default depth is 512 words of
//   40 bits. Read timing is standard, not first-word-fall-through: an accepted
//   read loads the oldest word into dout on the same edge. dout then holds that
//   value until the next accepted read.
//
// Ports
//   clk    in   single clock; all state changes occur on its rising edge
//   rst    in   asynchronous, active-high reset
//   din    in   [DATA_WIDTH-1:0] write data
//   wr_en  in   write request; accepted only when the FIFO is not full
//   rd_en  in   read request; accepted only when the FIFO is not empty
//   dout   out  [DATA_WIDTH-1:0] registered read data
//   full   out  registered; high when 2**ADDR_WIDTH words are stored
//   empty  out  registered; high when no words are stored
// -----------------------------------------------------------------------------
module sync_fifo_512 #(
    parameter int DATA_WIDTH = 40,
    parameter int ADDR_WIDTH = 9
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  wr_en,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  full,
    output logic                  empty
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    // Occupancy value that means "full": a 1 in the MSB and zeros below it.
    localparam logic [ADDR_WIDTH:0] FULL_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};

    // Storage is deliberately left out of reset so it can map onto block RAM.
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   count;
    logic [ADDR_WIDTH:0]   count_nxt;

    logic wr_acc;
    logic rd_acc;

    // Acceptance is qualified by the registered flags. When the FIFO is full
    // and both requests are high, only the read is accepted. When it is empty
    // and both are high, only the write is accepted.
    assign wr_acc = wr_en && !full;
    assign rd_acc = rd_en && !empty;

    always_comb begin
        count_nxt = count;
        unique case ({wr_acc, rd_acc})
            2'b10:   count_nxt = count + 1'b1;
            2'b01:   count_nxt = count - 1'b1;
            default: count_nxt = count;
        endcase
    end

    // Storage write. The write is also blocked while reset is held, so a
    // request made during reset never reaches the array.
    always_ff @(posedge clk) begin
        if (wr_acc && !rst) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers, count, flags and read data.
    // If a read and a write are both accepted on one edge, count is between 1
    // and DEPTH-1. That keeps rd_ptr and wr_ptr on different addresses, so the
    // read never sees the word being written on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            dout   <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + 1'b1;   // wraps naturally modulo DEPTH
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + 1'b1;
                dout   <= mem[rd_ptr];
            end
            count <= count_nxt;
            // Flags are driven from the next count, so they are exact right
            // after the edge.
            full  <= (count_nxt == FULL_CNT);
            empty <= (count_nxt == '0);
        end
    end

endmodule

// File: tb/tb_sync_fifo_512.sv
// -----------------------------------------------------------------------------
// tb_sync_fifo_512
//   Self-checking bench for sync_fifo_512. The reference model is a queue of
//   words plus the expected dout value. Each clock edge is applied to both the
//   DUT and the queue, and the bench then compares full, empty and dout.
// -----------------------------------------------------------------------------
module tb_sync_fifo_512;

    localparam int DW    = 40;
    localparam int AW    = 9;
    localparam int DEPTH = 512;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] din;
    logic          wr_en;
    logic          rd_en;
    logic [DW-1:0] dout;
    logic          full;
    logic          empty;

    sync_fifo_512 #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk   (clk),
        .rst   (rst),
        .din   (din),
        .wr_en (wr_en),
        .rd_en (rd_en),
        .dout  (dout),
        .full  (full),
        .empty (empty)
    );

    always #5 clk = ~clk;

    // Reference model state.
    logic [DW-1:0] q[$];
    logic [DW-1:0] exp_dout;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, ".full"},  {63'd0, full},  {63'd0, q.size() == DEPTH});
        check({tag, ".empty"}, {63'd0, empty}, {63'd0, q.size() == 0});
        check({tag, ".dout"},  {24'd0, dout},  {24'd0, exp_dout});
    endtask

    function automatic logic [DW-1:0] rnd_word();
        logic [63:0] w;
        w = {$urandom, $urandom};
        return w[DW-1:0];
    endfunction

    // Applies one clock edge with the given requests. The bench is at posedge+1
    // on entry and on exit, so inputs never change close to an active edge.
    task automatic step(input logic w, input logic r, input logic [DW-1:0] d, input string tag);
        bit wacc, racc;
        wr_en = w;
        rd_en = r;
        din   = d;
        wacc  = w && (q.size() < DEPTH);
        racc  = r && (q.size() > 0);
        @(posedge clk);
        if (racc) exp_dout = q.pop_front();
        if (wacc) q.push_back(d);
        #1;
        check_state(tag);
    endtask

    // Synchronous-looking reset pulse for a clean start. It is asserted and
    // released away from clock edges.
    task automatic do_reset();
        wr_en = 1'b0;
        rd_en = 1'b0;
        #2 rst = 1'b1;
        q.delete();
        exp_dout = '0;
        #20 rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst      = 1'b1;
        din      = '0;
        wr_en    = 1'b0;
        rd_en    = 1'b0;
        exp_dout = '0;
        #22;
        check_state("reset_init");
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_state("post_reset");

        // Fill: din = 1..513. The 513th write finds the FIFO full and is dropped.
        for (int i = 1; i <= DEPTH + 1; i++) step(1'b1, 1'b0, DW'(i), "fill");
        check("fill.full_at_end", {63'd0, full}, 64'd1);

        // Full with both requests high: only the read happens, the new word is
        // discarded, and the count drops to 511.
        step(1'b1, 1'b1, 40'hDEAD_BEEF_00, "full_both");
        check("full_both.dout", {24'd0, dout}, 64'd1);

        // Refill to full, then drain. dout must show 2..512 in order, then the
        // refill word, and then hold.
        step(1'b1, 1'b0, DW'(513), "refill");
        for (int i = 0; i < DEPTH + 2; i++) step(1'b0, 1'b1, '0, "drain");
        check("drain.dout_hold", {24'd0, dout}, 64'd513);

        // Empty with both requests high: only the write happens, the count
        // becomes 1, and dout is unchanged.
        step(1'b1, 1'b1, 40'h12_3456_789A, "empty_both");
        check("empty_both.dout", {24'd0, dout}, 64'd513);
        step(1'b0, 1'b1, '0, "empty_both_rd");

        // Simultaneous read and write at count 5, held for 10 clocks.
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, rnd_word(), "sim_fill");
        for (int i = 0; i < 10; i++) step(1'b1, 1'b1, rnd_word(), "sim_both");
        check("sim_both.size", 64'(q.size()), 64'd5);

        // Mid-stream reset with words stored. Requests are held high during the
        // pulse, and the reset must clear the outputs immediately.
        #2;
        rst   = 1'b1;
        wr_en = 1'b1;
        rd_en = 1'b1;
        din   = rnd_word();
        q.delete();
        exp_dout = '0;
        #1;
        check_state("mid_reset_now");
        #49;
        check_state("mid_reset_held");
        rst   = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
        @(posedge clk);
        #1;
        // A read after reset with no writes must leave dout at 0.
        step(1'b0, 1'b1, '0, "rd_after_reset");
        step(1'b0, 1'b1, '0, "rd_after_reset2");

        // Wrap: write 300 words, read 300, then write 400 and read 400. The
        // second batch crosses pointer 511 -> 0.
        do_reset();
        for (int i = 0; i < 300; i++) step(1'b1, 1'b0, rnd_word(), "wrap_w300");
        for (int i = 0; i < 300; i++) step(1'b0, 1'b1, '0, "wrap_r300");
        for (int i = 0; i < 400; i++) step(1'b1, 1'b0, rnd_word(), "wrap_w400");
        for (int i = 0; i < 400; i++) step(1'b0, 1'b1, '0, "wrap_r400");

        // Random traffic. The write/read bias changes per phase, so runs reach
        // both full and empty.
        for (int ph = 0; ph < 6; ph++) begin
            int pw;
            case (ph % 3)
                0:       pw = 80;
                1:       pw = 20;
                default: pw = 50;
            endcase
            for (int i = 0; i < 700; i++) begin
                step($urandom_range(99) < pw, $urandom_range(99) >= pw - 10 || $urandom_range(1) == 1,
                     rnd_word(), "random");
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
